// File: rtl/sme_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sme_pkg
//  Description : Shared types and limits for the string-match-engine arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package sme_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_LOAD  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } sme_state_t;

    localparam int STR_MAX     = 32;
    localparam int PAT_MAX     = 8;
    localparam int CHAR_W      = 8;
    localparam int IDX_W       = 5;
    localparam int TIMEOUT_MAX = 255;

endpackage
`default_nettype wire

// File: rtl/sme_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : sme_rr_arb
//  Description : Two-way round-robin selector; advance[n] marks requester n
//                as just served so the other one wins the next tie.
//  Revision    : 1.0 - initial release
// ============================================================================
module sme_rr_arb (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [1:0] advance,
    output logic [1:0] grant
);

    logic r_prio1;  // high when requester 1 wins a tie

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prio1 <= 1'b0;
        end else if (advance[0]) begin
            r_prio1 <= 1'b1;
        end else if (advance[1]) begin
            r_prio1 <= 1'b0;
        end
    end

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = r_prio1 ? 2'b10 : 2'b01;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sme_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sme_arbiter
//  Description : Shares one matcher engine between two hosts; forwards the
//                granted host's bytes and returns the engine result.
//                Define SME_ARB_TIMEOUT_EN to add the WAIT-state watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module sme_arbiter
    import sme_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    output logic [1:0]        gnt,
    input  logic [CHAR_W-1:0] h0_chardata,
    input  logic [CHAR_W-1:0] h1_chardata,
    input  logic              h0_isstring,
    input  logic              h1_isstring,
    input  logic              h0_ispattern,
    input  logic              h1_ispattern,
    output logic [1:0]        done,
    output logic              match,
    output logic [IDX_W-1:0]  match_index,
    output logic              err,
    output logic [CHAR_W-1:0] e_chardata,
    output logic              e_isstring,
    output logic              e_ispattern,
    input  logic              e_valid,
    input  logic              e_match,
    input  logic [IDX_W-1:0]  e_match_index
);

    sme_state_t        r_state;
    logic [1:0]        r_gnt;
    logic [1:0]        r_done;
    logic              r_match;
    logic [IDX_W-1:0]  r_idx;
    logic [CHAR_W-1:0] r_e_char;
    logic              r_e_str;
    logic              r_e_pat;
    logic [5:0]        r_str_cnt;
    logic [3:0]        r_pat_cnt;
    logic              r_str_seen;
    logic              r_pat_seen;
`ifdef SME_ARB_TIMEOUT_EN
    logic [7:0]        r_wd;
    logic              r_err;
`endif

    logic [CHAR_W-1:0] w_chardata;
    logic              w_ispat;
    logic              w_isstr;
    logic              w_req_gnt;
    logic              w_abort;
    logic [1:0]        w_rr_gnt;
    logic [1:0]        w_advance;
    logic [5:0]        w_str_base;

    assign w_chardata = r_gnt[1] ? h1_chardata : h0_chardata;
    assign w_ispat    = r_gnt[1] ? h1_ispattern : h0_ispattern;
    assign w_isstr    = (r_gnt[1] ? h1_isstring : h0_isstring) & ~w_ispat;
    assign w_req_gnt  = |(req & r_gnt);
    assign w_abort    = ((r_state == ST_GRANT) || (r_state == ST_LOAD)) &&
                        !r_pat_seen && !w_req_gnt;
    assign w_advance  = ((r_state == ST_RESP) || w_abort) ? r_gnt : 2'b00;
    // The first string byte of a job restarts the string count from zero.
    assign w_str_base = r_str_seen ? r_str_cnt : 6'd0;

    sme_rr_arb u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (w_advance),
        .grant   (w_rr_gnt)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_gnt      <= 2'b00;
            r_done     <= 2'b00;
            r_match    <= 1'b0;
            r_idx      <= '0;
            r_e_char   <= '0;
            r_e_str    <= 1'b0;
            r_e_pat    <= 1'b0;
            r_str_cnt  <= 6'd0;
            r_pat_cnt  <= 4'd0;
            r_str_seen <= 1'b0;
            r_pat_seen <= 1'b0;
`ifdef SME_ARB_TIMEOUT_EN
            r_wd       <= 8'd0;
            r_err      <= 1'b0;
`endif
        end else begin
            r_done <= 2'b00;
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        r_gnt      <= w_rr_gnt;
                        r_pat_cnt  <= 4'd0;
                        r_pat_seen <= 1'b0;
                        r_str_seen <= 1'b0;
                        r_state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (w_abort) begin
                        r_gnt   <= 2'b00;
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_e_char <= '0;
                    r_e_str  <= 1'b0;
                    r_e_pat  <= 1'b0;
                    if (w_abort) begin
                        r_gnt   <= 2'b00;
                        r_state <= ST_IDLE;
                    end else begin
                        if (w_ispat) begin
                            if (r_pat_cnt < 4'(PAT_MAX)) begin
                                r_e_char   <= w_chardata;
                                r_e_pat    <= 1'b1;
                                r_pat_cnt  <= r_pat_cnt + 4'd1;
                                r_pat_seen <= 1'b1;
                            end
                        end else if (w_isstr) begin
                            r_str_seen <= 1'b1;
                            if (w_str_base < 6'(STR_MAX)) begin
                                r_e_char  <= w_chardata;
                                r_e_str   <= 1'b1;
                                r_str_cnt <= w_str_base + 6'd1;
                            end
                        end
                        if (!w_ispat && r_pat_seen) begin
                            r_state <= ST_WAIT;
`ifdef SME_ARB_TIMEOUT_EN
                            r_wd    <= 8'd0;
`endif
                        end
                    end
                end
                ST_WAIT: begin
                    r_e_char <= '0;
                    r_e_str  <= 1'b0;
                    r_e_pat  <= 1'b0;
                    if (e_valid) begin
                        r_match <= e_match;
                        r_idx   <= e_match_index;
                        r_done  <= r_gnt;
                        r_state <= ST_RESP;
`ifdef SME_ARB_TIMEOUT_EN
                        r_err   <= 1'b0;
                    end else if (r_wd == 8'(TIMEOUT_MAX - 1)) begin
                        r_match <= 1'b0;
                        r_idx   <= '0;
                        r_done  <= r_gnt;
                        r_err   <= 1'b1;
                        r_state <= ST_RESP;
                    end else begin
                        r_wd    <= r_wd + 8'd1;
`endif
                    end
                end
                ST_RESP: begin
                    r_gnt   <= 2'b00;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt         = r_gnt;
    assign done        = r_done;
    assign match       = r_match;
    assign match_index = r_idx;
    assign e_chardata  = r_e_char;
    assign e_isstring  = r_e_str;
    assign e_ispattern = r_e_pat;
`ifdef SME_ARB_TIMEOUT_EN
    assign err         = r_err;
`else
    assign err         = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/sme_arbiter.md
SME_ARBITER -- requirements
Module: sme_arbiter

Interface
- REQ-001 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
- REQ-002 SHALL have ports: reset  in  1  synchronous, active-low reset.
- REQ-003 SHALL have ports: req  in  2  per-requester job request, bit n = requester n.
- REQ-004 SHALL have ports: gnt  out  2  one-hot grant, at most one bit set.
- REQ-005 SHALL have ports: h0_chardata/h1_chardata  in  8 each  host character byte.
- REQ-006 SHALL have ports: h0_isstring/h1_isstring, h0_ispattern/h1_ispattern  in  1 each  host byte qualifiers.
- REQ-007 SHALL have ports: done  out  2  one-cycle result pulse to the granted requester.
- REQ-008 SHALL have ports: match  out  1, match_index  out  5  result of the last completed job.
- REQ-009 SHALL have ports: err  out  1  timeout flag, valid with done.
- REQ-010 SHALL have ports: e_chardata  out  8, e_isstring  out  1, e_ispattern  out  1  registered drive to the matcher engine.
- REQ-011 SHALL have ports: e_valid  in  1, e_match  in  1, e_match_index  in  5  engine result.

Function
- REQ-012 SHALL implement the FSM IDLE -> GRANT -> LOAD -> WAIT -> RESP -> IDLE.
- REQ-013 IDLE with any req bit set SHALL go to GRANT, selecting one requester by round-robin; on simultaneous requests the requester not served last wins; after reset requester 0 has priority.
- REQ-014 gnt SHALL assert in GRANT, one cycle after the request is sampled, and hold through RESP.
- REQ-015 LOAD SHALL forward only the granted host's chardata, isstring and ispattern to the e_* outputs with exactly one cycle of register latency; non-granted host inputs SHALL be ignored.
- REQ-016 SHALL count forwarded string bytes (6-bit, max 32) and pattern bytes (4-bit, max 8); bytes beyond 32 string or 8 pattern SHALL be dropped (e_is* low).
- REQ-017 The pattern count SHALL reset at each job start; the string count SHALL reset on the first isstring byte of a job.
- REQ-018 A job containing zero string bytes SHALL be legal, reusing the engine's prior string.
- REQ-019 LOAD SHALL go to WAIT on the first cycle where the granted host's ispattern=0 after at least one pattern byte has been forwarded.
- REQ-020 WAIT SHALL hold until e_valid=1, then capture e_match and e_match_index and go to RESP.
- REQ-021 RESP SHALL pulse done[granted] for exactly one cycle, then clear gnt, update the round-robin pointer and return to IDLE.
- REQ-022 match and match_index SHALL hold their values until the next done.
- REQ-023 If req[granted] drops in GRANT or LOAD before any pattern byte, the block SHALL abort to IDLE with no done pulse, drive e_* to zero, and advance the pointer.
- REQ-024 If e_valid arrives outside WAIT, it SHALL be ignored.
- REQ-025 If both isstring and ispattern are high, pattern SHALL take precedence.

Reset
- REQ-026 With reset=0 at a clock edge, the block SHALL clear: state=IDLE, gnt=0, done=0, match=0, match_index=0, err=0, all e_* outputs=0, counters=0, round-robin pointer=requester 0.
- REQ-027 Reset mid-job SHALL discard the job with no done pulse.

Configuration
- REQ-028 SME_ARB_TIMEOUT_EN defined: an 8-bit watchdog SHALL count WAIT cycles; on reaching 255 without e_valid, the block SHALL go to RESP with err=1, match=0, match_index=0.
- REQ-029 SME_ARB_TIMEOUT_EN undefined: WAIT SHALL be unbounded, and err SHALL be constant 0 with the port retained.

Structure
- REQ-030 Package sme_pkg SHALL hold the FSM state enum, STR_MAX=32, PAT_MAX=8, CHAR_W=8, IDX_W=5 and TIMEOUT_MAX=255.
- REQ-031 Round-robin selection and pointer SHALL live in sub-module sme_rr_arb (inputs: req, advance; output: one-hot grant).

Verification
- REQ-032 req=2'b01, host0 sends string "hello world" then pattern "wor"; engine e_valid with match=1, index=6 -> done=2'b01, match=1, match_index=6, e_* equal host0 bytes delayed one cycle.
- REQ-033 req=2'b11 asserted in the same cycle, twice in succession -> first gnt=01, then gnt=10, with no overlap.
- REQ-034 Host sends 40 string bytes and 10 pattern bytes -> exactly 32 and 8 bytes forwarded on e_*.
- REQ-035 req[0] drops after 3 string bytes -> return to IDLE, no done, e_*=0 the next cycle.
- REQ-036 With SME_ARB_TIMEOUT_EN defined and e_valid never asserted -> done after 255 WAIT cycles with err=1, match=0.
- REQ-037 reset=0 asserted during WAIT -> all outputs zero the next cycle; a later e_valid is ignored.
